// File: rtl/bloke2_msg_packer.sv
`default_nettype none
// ============================================================================
// Module   : bloke2_msg_packer
// Purpose  : Byte-stream to 16-word message-block packer for the bloke2 hash
//            family. Packs bytes little-endian, zero-pads the last block,
//            tracks the running byte count and flags the final block.
//            A full block is held until the packer knows whether more data
//            follows, so a non-final block is never emitted at end of message.
// Revision : 1.0 - initial release
// ============================================================================
module bloke2_msg_packer #(
  parameter int W     = 64,   // word width: 32 or 64
  parameter int CNT_W = 64    // byte counter width, wraps
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        din,
  input  logic              din_valid,
  output logic              din_ready,
  input  logic              din_end,
  output logic [16*W-1:0]   blk_data,
  output logic [CNT_W-1:0]  blk_cnt,
  output logic              blk_last,
  output logic              blk_valid,
  input  logic              blk_ready
);

  // Bytes per block and widths of the fill counter / byte index.
  localparam int BB = 2 * W;
  localparam int IW = $clog2(BB);
  localparam int NW = IW + 1;
  localparam logic [NW-1:0] BB_M1 = NW'(BB - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    FULL = 2'd2,
    EMIT = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [16*W-1:0]  blk_buf;
  logic [NW-1:0]    fill_n;
  logic [CNT_W-1:0] byte_cnt;
  logic             last_flag;

  logic accept;      // a byte is consumed this cycle
  logic set_last;    // entering EMIT: capture last_val
  logic last_val;
  logic begin_msg;   // start honoured in IDLE
  logic consume;     // block handed off downstream

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode, handshake strobes and gated block outputs.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    set_last  = 1'b0;
    last_val  = 1'b0;
    begin_msg = 1'b0;
    consume   = 1'b0;
    din_ready = 1'b0;
    blk_valid = 1'b0;
    blk_data  = '0;
    blk_cnt   = '0;
    blk_last  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          begin_msg = 1'b1;
          state_nxt = FILL;
        end
      end
      FILL: begin
        din_ready = 1'b1;
        if (din_valid) begin
          accept = 1'b1;
          if (din_end) begin
            // End strobe wins even when this byte also fills the block.
            state_nxt = EMIT;
            set_last  = 1'b1;
            last_val  = 1'b1;
          end else if (fill_n == BB_M1) begin
            state_nxt = FULL;
          end
        end else if (din_end) begin
          state_nxt = EMIT;
          set_last  = 1'b1;
          last_val  = 1'b1;
        end
      end
      FULL: begin
        // Peek only: a pending byte proves the block is not the last one.
        if (din_valid) begin
          state_nxt = EMIT;
          set_last  = 1'b1;
          last_val  = 1'b0;
        end else if (din_end) begin
          state_nxt = EMIT;
          set_last  = 1'b1;
          last_val  = 1'b1;
        end
      end
      EMIT: begin
        blk_valid = 1'b1;
        blk_data  = blk_buf;
        blk_cnt   = byte_cnt;
        blk_last  = last_flag;
        if (blk_ready) begin
          consume   = 1'b1;
          state_nxt = last_flag ? IDLE : FILL;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Block buffer, fill count, running byte count and last flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      blk_buf   <= '0;
      fill_n    <= '0;
      byte_cnt  <= '0;
      last_flag <= 1'b0;
    end else begin
      if (begin_msg) begin
        blk_buf  <= '0;
        fill_n   <= '0;
        byte_cnt <= '0;
      end
      if (accept) begin
        blk_buf[{fill_n[IW-1:0], 3'b000} +: 8] <= din;
        fill_n   <= fill_n + NW'(1);
        byte_cnt <= byte_cnt + CNT_W'(1);
      end
      if (set_last) last_flag <= last_val;
      // Byte count is kept across blocks; only the buffer restarts.
      if (consume) begin
        blk_buf <= '0;
        fill_n  <= '0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bloke2_msg_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_bloke2_msg_packer
// Purpose  : Directed self-checking bench for bloke2_msg_packer (W=64 and W=32)
// Revision : 1.0 - initial release
// ============================================================================
module tb_bloke2_msg_packer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // W=64 instance
  logic          start = 0, din_valid = 0, din_end = 0, blk_ready = 0;
  logic [7:0]    din = 0;
  logic          din_ready, blk_last, blk_valid;
  logic [1023:0] blk_data;
  logic [63:0]   blk_cnt;

  // W=32 instance
  logic          s_start = 0, s_din_valid = 0, s_din_end = 0, s_blk_ready = 0;
  logic [7:0]    s_din = 0;
  logic          s_din_ready, s_blk_last, s_blk_valid;
  logic [511:0]  s_blk_data;
  logic [63:0]   s_blk_cnt;

  int checks = 0;
  int errors = 0;

  bloke2_msg_packer #(.W(64), .CNT_W(64)) dut64 (
    .clk(clk), .rst(rst), .start(start), .din(din), .din_valid(din_valid),
    .din_ready(din_ready), .din_end(din_end), .blk_data(blk_data),
    .blk_cnt(blk_cnt), .blk_last(blk_last), .blk_valid(blk_valid),
    .blk_ready(blk_ready));

  bloke2_msg_packer #(.W(32), .CNT_W(64)) dut32 (
    .clk(clk), .rst(rst), .start(s_start), .din(s_din), .din_valid(s_din_valid),
    .din_ready(s_din_ready), .din_end(s_din_end), .blk_data(s_blk_data),
    .blk_cnt(s_blk_cnt), .blk_last(s_blk_last), .blk_valid(s_blk_valid),
    .blk_ready(s_blk_ready));

  // Advance one cycle; inputs change and outputs are sampled on the negedge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic e);
    din = b; din_valid = 1; din_end = e;
    tick();
    din_valid = 0; din_end = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    tick(); tick();
    checks++;
    if ({din_ready, blk_valid, blk_last} !== 3'b000 || blk_data !== '0 || blk_cnt !== 64'd0) begin
      errors++;
      $display("FAIL reset64: ready/valid/last=%b cnt=%0d expected 000 cnt=0",
               {din_ready, blk_valid, blk_last}, blk_cnt);
    end
    checks++;
    if ({s_din_ready, s_blk_valid, s_blk_last} !== 3'b000 || s_blk_data !== '0 || s_blk_cnt !== 64'd0) begin
      errors++;
      $display("FAIL reset32: ready/valid/last=%b cnt=%0d expected 000 cnt=0",
               {s_din_ready, s_blk_valid, s_blk_last}, s_blk_cnt);
    end
    rst = 0;
    tick();
  endtask

  task automatic test_empty();
    start = 1; tick(); start = 0;
    checks++;
    if (din_ready !== 1'b1) begin
      errors++; $display("FAIL empty_fill_ready: got %b expected 1", din_ready);
    end
    din_end = 1; tick(); din_end = 0;
    checks++;
    if (blk_valid !== 1'b1 || blk_data !== '0 || blk_cnt !== 64'd0 || blk_last !== 1'b1) begin
      errors++;
      $display("FAIL empty_block: valid=%b cnt=%0d last=%b data_nz=%b expected 1 0 1 0",
               blk_valid, blk_cnt, blk_last, |blk_data);
    end
    blk_ready = 1; tick(); blk_ready = 0;
    // Back in IDLE: no block, no ready, and din_valid alone is not accepted.
    din_valid = 1; din = 8'hAA; tick(); din_valid = 0;
    checks++;
    if (blk_valid !== 1'b0 || din_ready !== 1'b0 || blk_cnt !== 64'd0) begin
      errors++;
      $display("FAIL empty_idle: valid=%b ready=%b cnt=%0d expected 0 0 0",
               blk_valid, din_ready, blk_cnt);
    end
  endtask

  // Sends "abc" after a start and checks the resulting single final block.
  task automatic run_abc(input string tag);
    logic [1023:0] exp;
    exp = '0;
    exp[23:0] = 24'h636261;
    start = 1; tick(); start = 0;
    send_byte(8'h61, 0);
    send_byte(8'h62, 0);
    checks++;
    if (blk_valid !== 1'b0) begin
      errors++; $display("FAIL %s_early_valid: got %b expected 0", tag, blk_valid);
    end
    send_byte(8'h63, 1);
    checks++;
    if (blk_valid !== 1'b1 || blk_data !== exp || blk_cnt !== 64'd3 || blk_last !== 1'b1) begin
      errors++;
      $display("FAIL %s_block: valid=%b data=%h cnt=%0d last=%b expected 1 %h 3 1",
               tag, blk_valid, blk_data[63:0], blk_cnt, blk_last, exp[63:0]);
    end
    tick(); tick();
    checks++;
    if (blk_valid !== 1'b1 || blk_data !== exp || blk_cnt !== 64'd3 || din_ready !== 1'b0) begin
      errors++;
      $display("FAIL %s_hold: valid=%b cnt=%0d ready=%b expected 1 3 0",
               tag, blk_valid, blk_cnt, din_ready);
    end
    blk_ready = 1; tick(); blk_ready = 0;
    checks++;
    if (blk_valid !== 1'b0 || blk_data !== '0 || blk_last !== 1'b0) begin
      errors++;
      $display("FAIL %s_drop: valid=%b last=%b expected 0 0", tag, blk_valid, blk_last);
    end
  endtask

  task automatic test_abc();
    run_abc("abc");
  endtask

  task automatic test_exact_block();
    logic [1023:0] exp;
    int early;
    early = 0;
    for (int i = 0; i < 128; i++) exp[8*i +: 8] = 8'(i);
    start = 1; tick(); start = 0;
    for (int i = 0; i < 128; i++) begin
      send_byte(8'(i), 0);
      if (blk_valid) early++;
    end
    checks++;
    if (din_ready !== 1'b0) begin
      errors++; $display("FAIL full_ready: got %b expected 0", din_ready);
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      if (blk_valid) early++;
    end
    checks++;
    if (early != 0) begin
      errors++; $display("FAIL full_early: valid seen %0d cycles expected 0", early);
    end
    din_end = 1; tick(); din_end = 0;
    checks++;
    if (blk_valid !== 1'b1 || blk_data !== exp || blk_cnt !== 64'd128 || blk_last !== 1'b1) begin
      errors++;
      $display("FAIL full_block: valid=%b cnt=%0d last=%b data_lo=%h expected 1 128 1 %h",
               blk_valid, blk_cnt, blk_last, blk_data[63:0], exp[63:0]);
    end
    blk_ready = 1; tick(); blk_ready = 0;
  endtask

  task automatic test_129();
    logic [1023:0] exp1, exp2;
    exp2 = '0;
    exp2[7:0] = 8'h80;
    for (int i = 0; i < 128; i++) exp1[8*i +: 8] = 8'(i);
    start = 1; tick(); start = 0;
    for (int i = 0; i < 128; i++) send_byte(8'(i), 0);
    // Present byte 129 as final byte; it stays on the port until accepted.
    din = 8'h80; din_valid = 1; din_end = 1;
    tick();
    checks++;
    if (blk_valid !== 1'b1 || blk_data !== exp1 || blk_cnt !== 64'd128 || blk_last !== 1'b0) begin
      errors++;
      $display("FAIL b129_first: valid=%b cnt=%0d last=%b expected 1 128 0",
               blk_valid, blk_cnt, blk_last);
    end
    blk_ready = 1; tick(); blk_ready = 0;
    checks++;
    if (din_ready !== 1'b1 || blk_valid !== 1'b0) begin
      errors++;
      $display("FAIL b129_refill: ready=%b valid=%b expected 1 0", din_ready, blk_valid);
    end
    tick();
    din_valid = 0; din_end = 0;
    checks++;
    if (blk_valid !== 1'b1 || blk_data !== exp2 || blk_cnt !== 64'd129 || blk_last !== 1'b1) begin
      errors++;
      $display("FAIL b129_second: valid=%b data_lo=%h cnt=%0d last=%b expected 1 80 129 1",
               blk_valid, blk_data[63:0], blk_cnt, blk_last);
    end
    blk_ready = 1; tick(); blk_ready = 0;
  endtask

  task automatic test_w32_stall();
    logic [511:0] exp1, exp2;
    int unstable;
    exp2 = '0;
    exp2[7:0] = 8'h40;
    for (int i = 0; i < 64; i++) exp1[8*i +: 8] = 8'(i);
    s_start = 1; tick(); s_start = 0;
    for (int i = 0; i < 64; i++) begin
      s_din = 8'(i); s_din_valid = 1; tick();
    end
    s_din = 8'h40; s_din_valid = 1; s_din_end = 1;
    tick();
    checks++;
    if (s_blk_valid !== 1'b1 || s_blk_data !== exp1 || s_blk_cnt !== 64'd64 || s_blk_last !== 1'b0) begin
      errors++;
      $display("FAIL w32_first: valid=%b cnt=%0d last=%b expected 1 64 0",
               s_blk_valid, s_blk_cnt, s_blk_last);
    end
    unstable = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (s_blk_valid !== 1'b1 || s_blk_data !== exp1 || s_blk_cnt !== 64'd64 ||
          s_blk_last !== 1'b0 || s_din_ready !== 1'b0) unstable++;
    end
    checks++;
    if (unstable != 0) begin
      errors++; $display("FAIL w32_stall1: %0d unstable cycles expected 0", unstable);
    end
    s_blk_ready = 1; tick(); s_blk_ready = 0;
    tick();
    s_din_valid = 0; s_din_end = 0;
    checks++;
    if (s_blk_valid !== 1'b1 || s_blk_data !== exp2 || s_blk_cnt !== 64'd65 || s_blk_last !== 1'b1) begin
      errors++;
      $display("FAIL w32_second: valid=%b data_lo=%h cnt=%0d last=%b expected 1 40 65 1",
               s_blk_valid, s_blk_data[63:0], s_blk_cnt, s_blk_last);
    end
    unstable = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (s_blk_valid !== 1'b1 || s_blk_data !== exp2 || s_blk_cnt !== 64'd65 ||
          s_blk_last !== 1'b1 || s_din_ready !== 1'b0) unstable++;
    end
    checks++;
    if (unstable != 0) begin
      errors++; $display("FAIL w32_stall2: %0d unstable cycles expected 0", unstable);
    end
    s_blk_ready = 1; tick(); s_blk_ready = 0;
    checks++;
    if (s_blk_valid !== 1'b0 || s_din_ready !== 1'b0) begin
      errors++;
      $display("FAIL w32_idle: valid=%b ready=%b expected 0 0", s_blk_valid, s_din_ready);
    end
  endtask

  task automatic test_reset_mid();
    start = 1; tick(); start = 0;
    for (int i = 0; i < 40; i++) send_byte(8'hF0 + 8'(i % 16), 0);
    rst = 1; tick(); rst = 0;
    checks++;
    if (blk_valid !== 1'b0 || din_ready !== 1'b0 || blk_cnt !== 64'd0) begin
      errors++;
      $display("FAIL midrst: valid=%b ready=%b cnt=%0d expected 0 0 0",
               blk_valid, din_ready, blk_cnt);
    end
    run_abc("rst_abc");
  endtask

  initial begin
    test_reset();
    test_empty();
    test_abc();
    test_exact_block();
    test_129();
    test_w32_stall();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
